barrel_shift_pipe: RTL and testbench
====================================

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), internal amount width; it is derived and never overridden.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, the request is valid.
REQ-006 SHALL have port in_ready, output, 1, the block accepts a request this cycle.
REQ-007 SHALL have port shift_en, input, 1: 1 = shift; 0 = pass operand and carry_in through unchanged.
REQ-008 SHALL have port inst, input, 8, ARM operand-2 field: [0] register-shift flag, [2:1] type (00 LSL, 01 LSR, 10 ASR, 11 ROR), [7:3] imm shamt.
REQ-009 SHALL have port rs_amt, input, 8, bits [7:0] of Rs, used when inst[0]=1.
REQ-010 SHALL have port operand, input, WIDTH, the value to shift.
REQ-011 SHALL have port carry_in, input, 1, current C flag.
REQ-012 SHALL have port out_valid, output, 1, result is valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port result, output, WIDTH, the shifted value.
REQ-015 SHALL have port carry_out, output, 1, shifter carry.

Function
REQ-016 A request SHALL transfer when in_valid && in_ready; a result SHALL transfer when out_valid && out_ready.
REQ-017 Pipeline SHALL be two registered stages. S1 latches the decoded amount, the type, special-case flags and the operand. S2 latches result and carry_out.
REQ-018 Latency SHALL be 2 cycles, accept to out_valid. Throughput SHALL be 1 per cycle when out_ready is held high.
REQ-019 A stage SHALL advance when it is empty or its downstream advances. in_ready = !s1_valid || s1 advancing, with no combinational path from in_valid.
REQ-020 While out_valid=1 && out_ready=0, result, carry_out and out_valid SHALL hold stable. No request SHALL be lost, duplicated or reordered.
REQ-021 Amount SHALL be n = inst[7:3] for immediate and n = rs_amt for register mode.
REQ-022 Immediate n=0 SHALL mean: LSL passes the operand with C=carry_in; LSR and ASR shift by WIDTH; ROR is RRX, giving {carry_in, op[W-1:1]} with C=op[0].
REQ-023 Register n=0 SHALL pass the operand with C=carry_in for all types.
REQ-024 LSL with 1<=n<W SHALL give C=op[W-n]. n=W SHALL give 0 with C=op[0]. n>W SHALL give 0 with C=0.
REQ-025 LSR with 1<=n<W SHALL give C=op[n-1]. n=W SHALL give 0 with C=op[W-1]. n>W SHALL give 0 with C=0.
REQ-026 ASR with 1<=n<W SHALL give C=op[n-1]. n>=W SHALL give all bits = op[W-1] with C=op[W-1].
REQ-027 ROR register n!=0 SHALL rotate by n mod W with C=result[W-1]; n mod W = 0 therefore returns op with C=op[W-1].
REQ-028 Shift arithmetic SHALL be unsigned on n with the full 8-bit compare; the amount is never truncated before the >=W checks.

Reset
REQ-029 While reset=1, stage valids and out_valid SHALL clear on the next edge, regardless of in-flight data or out_ready.
REQ-030 In the cycle after reset deasserts, in_ready SHALL be 1. result and carry_out SHALL reset to 0.

Structure
REQ-031 Package shift_pkg SHALL hold the shift-type enum (LSL/LSR/ASR/ROR encodings) and the inst field bit-position constants.
REQ-032 The combinational result/carry computation SHALL be sub-module barrel_shift_core (WIDTH parameter), instantiated between S1 and S2. Handshake logic SHALL stay in the top module.

Verification (WIDTH=32)
REQ-033 LSL imm #4, op=0xF000000F, cin=0 -> result 0x000000F0, C=1, out_valid 2 cycles after accept.
REQ-034 ROR imm #0 (RRX), op=0x00000001, cin=1 -> 0x80000000, C=1.
REQ-035 ASR reg, rs_amt=0x40, op=0x80000000 -> 0xFFFFFFFF, C=1. The same with op=0x7FFFFFFF -> 0x00000000, C=0.
REQ-036 LSR reg, op=0x80000001: rs_amt=32 -> 0, C=1; rs_amt=33 -> 0, C=0; rs_amt=0 with cin=1 -> 0x80000001, C=1.
REQ-037 Backpressure: issue 4 back-to-back requests with out_ready=0 for 3 cycles -> in_ready falls after 2 are held. Outputs stay stable. On release all 4 emerge in order, 1 per cycle.
REQ-038 Reset mid-operation: assert reset with both stages valid -> next cycle out_valid=0. After deassert in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared shift-type encodings and ARM operand-2 field positions.
package shift_pkg;

  // Shift type as encoded in inst[2:1]
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  // Bit positions inside the 8-bit inst field
  localparam int INST_REG_BIT   = 0;
  localparam int INST_TYPE_LSB  = 1;
  localparam int INST_TYPE_MSB  = 2;
  localparam int INST_SHAMT_LSB = 3;
  localparam int INST_SHAMT_MSB = 7;

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational ARM barrel shifter: result and carry from a decoded amount.
// The amount arrives as the full 8-bit value (imm LSR/ASR #0 already mapped to
// WIDTH), so the >=WIDTH checks see the untruncated number.
module barrel_shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [7:0]       amt,
  input  shift_type_e      sh_type,
  input  logic             pass,
  input  logic             rrx,
  input  logic [WIDTH-1:0] op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [7:0] WIDTH_AMT = 8'(WIDTH);

  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   neg_sh;
  logic [SHW-1:0]   dec_sh;
  logic             lt_w;
  logic             eq_w;
  logic [WIDTH-1:0] rot;

  // Shift/rotate datapath with ARM carry rules for each type and range of n
  always_comb begin
    sh        = amt[SHW-1:0];
    neg_sh    = '0 - sh;          // WIDTH-n for 1<=n<WIDTH
    dec_sh    = sh - SHW'(1);     // n-1 for 1<=n<WIDTH
    lt_w      = (amt < WIDTH_AMT);
    eq_w      = (amt == WIDTH_AMT);
    rot       = (op >> sh) | (op << neg_sh);
    result    = '0;
    carry_out = 1'b0;
    if (pass) begin
      result    = op;
      carry_out = cin;
    end else if (rrx) begin
      result    = {cin, op[WIDTH-1:1]};
      carry_out = op[0];
    end else begin
      case (sh_type)
        SH_LSL: begin
          if (lt_w) begin
            result    = op << sh;
            carry_out = op[neg_sh];
          end else if (eq_w) begin
            carry_out = op[0];
          end
        end
        SH_LSR: begin
          if (lt_w) begin
            result    = op >> sh;
            carry_out = op[dec_sh];
          end else if (eq_w) begin
            carry_out = op[WIDTH-1];
          end
        end
        SH_ASR: begin
          if (lt_w) begin
            result    = $unsigned($signed(op) >>> sh);
            carry_out = op[dec_sh];
          end else begin
            result    = {WIDTH{op[WIDTH-1]}};
            carry_out = op[WIDTH-1];
          end
        end
        default: begin
          // rotate by n mod WIDTH; zero rotation leaves op and C = op[MSB]
          result    = rot;
          carry_out = rot[WIDTH-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Two-stage pipelined ARM operand-2 barrel shifter with valid/ready flow control.
// S1 holds the decoded request, S2 holds the result.
// Handshake: a request transfers on a cycle where in_valid && in_ready; a result
// transfers where out_valid && out_ready. in_ready depends only on pipeline
// state and out_ready, never on in_valid. Held outputs stay stable under stall.
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  input  logic [7:0]       inst,
  input  logic [7:0]       rs_amt,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [7:0] WIDTH_AMT = 8'(WIDTH);

  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       s1_amt_q, s1_amt_d;
  shift_type_e      s1_type_q, s1_type_d;
  logic             s1_pass_q, s1_pass_d;
  logic             s1_rrx_q, s1_rrx_d;
  logic [WIDTH-1:0] s1_op_q, s1_op_d;
  logic             s1_cin_q, s1_cin_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;

  logic             s2_adv, s1_adv, in_fire;
  logic             dec_reg, dec_n_zero;
  logic [7:0]       dec_n;
  shift_type_e      dec_type;
  logic [WIDTH-1:0] core_res;
  logic             core_c;

  // Stage advance: a stage moves when empty or when its downstream moves
  always_comb begin
    s2_adv  = !out_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    in_fire = in_valid && s1_adv;
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;

  // Decode amount and the zero-amount special cases from inst
  always_comb begin
    dec_reg    = inst[INST_REG_BIT];
    dec_type   = shift_type_e'(inst[INST_TYPE_MSB:INST_TYPE_LSB]);
    dec_n      = dec_reg ? rs_amt : {3'b000, inst[INST_SHAMT_MSB:INST_SHAMT_LSB]};
    dec_n_zero = (dec_n == 8'd0);
  end

  // S1 next state: load the decoded request on transfer, clear when drained
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_amt_d   = s1_amt_q;
    s1_type_d  = s1_type_q;
    s1_pass_d  = s1_pass_q;
    s1_rrx_d   = s1_rrx_q;
    s1_op_d    = s1_op_q;
    s1_cin_d   = s1_cin_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_type_d = dec_type;
      s1_op_d   = operand;
      s1_cin_d  = carry_in;
      s1_pass_d = !shift_en || (dec_n_zero && (dec_reg || dec_type == SH_LSL));
      s1_rrx_d  = shift_en && !dec_reg && dec_n_zero && (dec_type == SH_ROR);
      // immediate LSR/ASR #0 encodes a shift by the full width
      s1_amt_d  = (!dec_reg && dec_n_zero &&
                   (dec_type == SH_LSR || dec_type == SH_ASR)) ? WIDTH_AMT : dec_n;
    end
  end

  barrel_shift_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .amt       (s1_amt_q),
    .sh_type   (s1_type_q),
    .pass      (s1_pass_q),
    .rrx       (s1_rrx_q),
    .op        (s1_op_q),
    .cin       (s1_cin_q),
    .result    (core_res),
    .carry_out (core_c)
  );

  // S2 next state: capture the core output when S1 moves forward
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_res;
        carry_d  = core_c;
      end
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_amt_q    <= '0;
      s1_type_q   <= SH_LSL;
      s1_pass_q   <= 1'b0;
      s1_rrx_q    <= 1'b0;
      s1_op_q     <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_amt_q    <= s1_amt_d;
      s1_type_q   <= s1_type_d;
      s1_pass_q   <= s1_pass_d;
      s1_rrx_q    <= s1_rrx_d;
      s1_op_q     <= s1_op_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=32): directed ARM cases,
// backpressure, mid-flight reset and randomized traffic against a reference model.
module tb_barrel_shift_pipe;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         shift_en;
  logic [7:0]   inst;
  logic [7:0]   rs_amt;
  logic [W-1:0] operand;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];   // {carry, result}

  logic       held;
  logic [W:0] held_val;
  logic       done;

  barrel_shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .inst      (inst),
    .rs_amt    (rs_amt),
    .operand   (operand),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference: ARM operand-2 shifter written from the architectural rules
  function automatic logic [W:0] model(input logic se, input logic [7:0] ins,
                                       input logic [7:0] rs, input logic [W-1:0] op,
                                       input logic cin);
    int         n;
    int         t;
    logic [63:0] dbl;
    logic [W-1:0] r;
    logic       c;
    t = int'(ins[2:1]);
    n = ins[0] ? int'(rs) : int'(ins[7:3]);
    if (!se) return {cin, op};
    if (n == 0) begin
      if (ins[0] || t == 0) return {cin, op};
      if (t == 3) return {op[0], cin, op[W-1:1]};
      n = W;
    end
    r = '0;
    c = 1'b0;
    case (t)
      0: begin
        if (n < W)       begin r = op << n; c = op[W-n]; end
        else if (n == W) begin r = '0; c = op[0]; end
      end
      1: begin
        if (n < W)       begin r = op >> n; c = op[n-1]; end
        else if (n == W) begin r = '0; c = op[W-1]; end
      end
      2: begin
        if (n < W) begin
          r = (op >> n) | (op[W-1] ? ~({W{1'b1}} >> n) : '0);
          c = op[n-1];
        end else begin
          r = {W{op[W-1]}};
          c = op[W-1];
        end
      end
      default: begin
        dbl = {op, op};
        r   = dbl[(n % W) +: W];
        c   = r[W-1];
      end
    endcase
    return {c, r};
  endfunction

  // driver: present a request, hold until accepted (bounded), record expectation
  task automatic send(input logic se, input logic [7:0] ins, input logic [7:0] rs,
                      input logic [W-1:0] op, input logic cin);
    int   waited;
    logic acc;
    waited   = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    shift_en = se;
    inst     = ins;
    rs_amt   = rs;
    operand  = op;
    carry_in = cin;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          fail_now("send_timeout");
          break;
        end
      end
    end
    if (acc) exp_q.push_back(model(se, ins, rs, op, cin));
    in_valid = 1'b0;
  endtask

  task automatic send_lit(input string name, input logic [7:0] ins, input logic [7:0] rs,
                          input logic [W-1:0] op, input logic cin, input logic [W:0] lit);
    chk(name, 64'(model(1'b1, ins, rs, op, cin)), 64'(lit));
    send(1'b1, ins, rs, op, cin);
  endtask

  // scoreboard: compare transfers in order and check stability under stall
  initial begin
    held     = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_data", 64'({carry_out, result}), 64'(held_val));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else chk("result", 64'({carry_out, result}), 64'(exp_q.pop_front()));
        end
        held     = out_valid && !out_ready;
        held_val = {carry_out, result};
      end
    end
  end

  initial begin
    logic [7:0] amt_tab [8];
    amt_tab = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd63, 8'd64, 8'd255};
    reset     = 1'b1;
    in_valid  = 1'b0;
    shift_en  = 1'b0;
    inst      = '0;
    rs_amt    = '0;
    operand   = '0;
    carry_in  = 1'b0;
    out_ready = 1'b1;
    done      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_carry", 64'(carry_out), 64'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2;

    // LSL imm #4 with latency check
    send_lit("lit_lsl4", 8'h20, 8'h00, 32'hF000000F, 1'b0, {1'b1, 32'h000000F0});
    @(negedge clk);
    chk("latency_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("latency", 64'(out_valid), 64'(1));
    @(posedge clk);
    #2;

    // RRX, ASR/LSR register boundary cases
    send_lit("lit_rrx",     8'h06, 8'h00, 32'h00000001, 1'b1, {1'b1, 32'h80000000});
    send_lit("lit_asr64_n", 8'h05, 8'h40, 32'h80000000, 1'b0, {1'b1, 32'hFFFFFFFF});
    send_lit("lit_asr64_p", 8'h05, 8'h40, 32'h7FFFFFFF, 1'b0, {1'b0, 32'h00000000});
    send_lit("lit_lsr32",   8'h03, 8'd32, 32'h80000001, 1'b0, {1'b1, 32'h00000000});
    send_lit("lit_lsr33",   8'h03, 8'd33, 32'h80000001, 1'b0, {1'b0, 32'h00000000});
    send_lit("lit_lsr0",    8'h03, 8'd0,  32'h80000001, 1'b1, {1'b1, 32'h80000001});
    send_lit("lit_ror_r32", 8'h07, 8'd32, 32'h80000001, 1'b0, {1'b1, 32'h80000001});
    send_lit("lit_lsl_r32", 8'h01, 8'd32, 32'h80000001, 1'b0, {1'b1, 32'h00000000});
    send(1'b0, 8'h20, 8'h00, 32'h12345678, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    chk("drain_directed", 64'(exp_q.size()), 64'(0));

    // backpressure: 4 back-to-back requests, consumer stalled
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(1'b1, 8'h02 | 8'(i << 3), 8'h00, 32'hA5A5_0000 + 32'(i), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_stream", 64'(out_valid), 64'(1));
        end
      end
    join
    repeat (3) @(posedge clk);
    #2;
    chk("bp_drain", 64'(exp_q.size()), 64'(0));

    // reset with both stages occupied
    out_ready = 1'b0;
    send(1'b1, 8'h21, 8'd5, 32'hDEADBEEF, 1'b1);
    send(1'b1, 8'h0B, 8'd7, 32'hCAFEF00D, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_result", 64'({carry_out, result}), 64'(0));
    @(posedge clk);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    repeat (5) @(posedge clk);
    #2;

    // randomized traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [7:0] ins;
          logic [7:0] rs;
          int         gap;
          ins = 8'($urandom_range(0, 255));
          rs  = ($urandom_range(0, 1) == 0) ? amt_tab[$urandom_range(0, 7)]
                                            : 8'($urandom_range(0, 255));
          send($urandom_range(0, 7) != 0, ins, rs, $urandom, 1'($urandom_range(0, 1)));
          gap = $urandom_range(0, 3);
          if (gap == 3) begin
            @(posedge clk);
            #2;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    chk("rand_drain", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
